// File: rtl/fp_pkg.sv
// Shared types and helpers for the pipelined floating-point adder.
// Every function here is written to work for any exponent and fraction width the adder supports.
package fp_pkg;

    typedef enum logic [2:0] {ZERO, SUB, NORM, INF, NAN} fp_class_e;

    typedef struct packed {
        logic invalid;
        logic overflow;
        logic inexact;
    } fp_flags_t;

    localparam int GRS_W = 3;

    // Canonical quiet NaN {0, all-ones exponent, 1, zeros}, built in a 64-bit container.
    function automatic logic [63:0] canon_qnan(input int exp_w, input int man_w);
        logic [63:0] q;
        q = '0;
        for (int i = 0; i < 64; i++)
            if (i >= man_w - 1 && i < man_w + exp_w) q[i] = 1'b1;
        return q;
    endfunction

    // Leading zeros in the low w bits of v; returns w when those bits are all zero.
    function automatic int lzc(input logic [63:0] v, input int w);
        int n;
        n = w;
        for (int i = 0; i < 64; i++)
            if (i < w && v[i]) n = w - 1 - i;
        return n;
    endfunction

endpackage

// File: rtl/fp_add_pipe_unpack.sv
// Combinational unpacker: classifies an operand and inserts the hidden bit.
// Subnormals and zeros are given effective exponent 1 and hidden bit 0.
module fp_unpack
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [EXP_W+MAN_W:0] x,
    input  logic                 neg,
    output logic                 sign,
    output logic [EXP_W-1:0]     eff_exp,
    output logic [MAN_W:0]       man,
    output fp_class_e            cls,
    output logic                 snan
);
    logic [EXP_W-1:0] raw_exp;
    logic [MAN_W-1:0] frac;

    assign raw_exp = x[EXP_W+MAN_W-1:MAN_W];
    assign frac    = x[MAN_W-1:0];

    always_comb begin
        sign    = x[EXP_W+MAN_W] ^ neg;
        eff_exp = raw_exp;
        man     = {1'b1, frac};
        cls     = NORM;
        snan    = 1'b0;
        if (raw_exp == '0) begin
            eff_exp = EXP_W'(1);
            man     = {1'b0, frac};
            cls     = (frac == '0) ? ZERO : SUB;
        end else if (raw_exp == '1) begin
            cls  = (frac == '0) ? INF : NAN;
            snan = (frac != '0) && !frac[MAN_W-1];
        end
    end

endmodule

// File: rtl/fp_add_pipe.sv
// Three-stage elastic IEEE-754 adder/subtractor: S1 unpack/swap/align, S2 add, S3 normalise/round/pack.
// Special operands are resolved in S1 and ride a bypass tag through the remaining stages.
module fp_add_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 op,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic [2:0]           flags
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int AW = MAN_W + 1 + GRS_W;
    localparam int SW = AW + 1;
    localparam logic [63:0]      QNAN64   = canon_qnan(EXP_W, MAN_W);
    localparam logic [W-1:0]     QNAN     = QNAN64[W-1:0];
    localparam logic [EXP_W-1:0] EXP_ONES = '1;

    // Handshake: a stage loads when it is empty or its successor loads this cycle;
    // a word moves on every edge where valid && ready, and out_ready may ripple back to in_ready.
    logic s1_valid, s2_valid;
    logic s1_load, s2_load, s3_load;

    assign s3_load  = !out_valid || out_ready;
    assign s2_load  = !s2_valid || s3_load;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = rst_n && s1_load;

    logic             sa, sb, sna, snb;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W:0]   ma, mb;
    fp_class_e        ca, cb;

    fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
        .x(a), .neg(1'b0), .sign(sa), .eff_exp(ea), .man(ma), .cls(ca), .snan(sna)
    );
    fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
        .x(b), .neg(op), .sign(sb), .eff_exp(eb), .man(mb), .cls(cb), .snan(snb)
    );

    logic             a_big, big_sign, small_sign, inf_inf;
    logic [EXP_W-1:0] big_exp, small_exp;
    logic [MAN_W:0]   big_man, small_man;
    logic [EXP_W:0]   exp_diff;
    int               align_sh;
    logic [AW-1:0]    small_ext, small_shr, lost_mask, small_al;
    logic             byp_n;
    logic [W-1:0]     byp_res_n;
    fp_flags_t        byp_flg_n;

    always_comb begin
        a_big      = {ea, ma} >= {eb, mb};
        big_sign   = a_big ? sa : sb;
        small_sign = a_big ? sb : sa;
        big_exp    = a_big ? ea : eb;
        small_exp  = a_big ? eb : ea;
        big_man    = a_big ? ma : mb;
        small_man  = a_big ? mb : ma;
        exp_diff   = {1'b0, big_exp} - {1'b0, small_exp};
        align_sh   = int'(exp_diff);
        if (align_sh > AW - 1) align_sh = AW - 1;
        // Bits shifted past S collapse into the sticky position.
        small_ext  = {small_man, {GRS_W{1'b0}}};
        small_shr  = small_ext >> align_sh;
        lost_mask  = (AW'(1) << align_sh) - AW'(1);
        small_al   = {small_shr[AW-1:1], small_shr[0] | (|(small_ext & lost_mask))};

        inf_inf    = (ca == INF) && (cb == INF) && (sa != sb);
        byp_n      = 1'b0;
        byp_res_n  = '0;
        byp_flg_n  = '0;
        if (ca == NAN || cb == NAN || inf_inf) begin
            byp_n             = 1'b1;
            byp_res_n         = QNAN;
            byp_flg_n.invalid = inf_inf | sna | snb;
        end else if (ca == INF) begin
            byp_n     = 1'b1;
            byp_res_n = {sa, EXP_ONES, {MAN_W{1'b0}}};
        end else if (cb == INF) begin
            byp_n     = 1'b1;
            byp_res_n = {sb, EXP_ONES, {MAN_W{1'b0}}};
        end
    end

    logic             s1_sub, s1_sign, s1_byp;
    logic [EXP_W-1:0] s1_exp;
    logic [AW-1:0]    s1_big, s1_small;
    logic [W-1:0]     s1_byp_res;
    fp_flags_t        s1_byp_flg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_sub     <= 1'b0;
            s1_sign    <= 1'b0;
            s1_byp     <= 1'b0;
            s1_exp     <= '0;
            s1_big     <= '0;
            s1_small   <= '0;
            s1_byp_res <= '0;
            s1_byp_flg <= '0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sub     <= big_sign ^ small_sign;
                s1_sign    <= big_sign;
                s1_byp     <= byp_n;
                s1_exp     <= big_exp;
                s1_big     <= {big_man, {GRS_W{1'b0}}};
                s1_small   <= small_al;
                s1_byp_res <= byp_res_n;
                s1_byp_flg <= byp_flg_n;
            end
        end
    end

    logic [SW-1:0]    sum_n;
    logic             s2_sub, s2_sign, s2_byp;
    logic [EXP_W-1:0] s2_exp;
    logic [SW-1:0]    s2_sum;
    logic [W-1:0]     s2_byp_res;
    fp_flags_t        s2_byp_flg;

    // Operands are magnitude-ordered, so the difference never goes negative.
    assign sum_n = s1_sub ? ({1'b0, s1_big} - {1'b0, s1_small})
                          : ({1'b0, s1_big} + {1'b0, s1_small});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid   <= 1'b0;
            s2_sub     <= 1'b0;
            s2_sign    <= 1'b0;
            s2_byp     <= 1'b0;
            s2_exp     <= '0;
            s2_sum     <= '0;
            s2_byp_res <= '0;
            s2_byp_flg <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sub     <= s1_sub;
                s2_sign    <= s1_sign;
                s2_byp     <= s1_byp;
                s2_exp     <= s1_exp;
                s2_sum     <= sum_n;
                s2_byp_res <= s1_byp_res;
                s2_byp_flg <= s1_byp_flg;
            end
        end
    end

    int               lz, lim, lsh;
    logic [AW-1:0]    nm;
    logic [EXP_W+1:0] ne, fe;
    logic             rnd_up;
    logic [MAN_W+1:0] rm;
    logic [W-1:0]     res_n;
    fp_flags_t        flg_n;

    always_comb begin
        lz  = lzc(64'(s2_sum[AW-1:0]), AW);
        lim = (s2_exp == '0) ? 0 : int'(s2_exp) - 1;
        lsh = (lz < lim) ? lz : lim;
        if (s2_sum[SW-1]) begin
            nm = {s2_sum[SW-1:2], s2_sum[1] | s2_sum[0]};
            ne = {2'b00, s2_exp} + (EXP_W+2)'(1);
        end else begin
            // Left shift stops at exponent 1; a hidden bit still 0 then means subnormal.
            nm = s2_sum[AW-1:0] << lsh;
            ne = {2'b00, s2_exp} - (EXP_W+2)'(lsh);
        end
        rnd_up = nm[2] & (nm[1] | nm[0] | nm[3]);
        rm     = {1'b0, nm[AW-1:GRS_W]} + (MAN_W+2)'(rnd_up);
        fe     = rm[MAN_W+1] ? ne + (EXP_W+2)'(1) : (rm[MAN_W] ? ne : '0);

        res_n = '0;
        flg_n = '0;
        if (s2_byp) begin
            res_n = s2_byp_res;
            flg_n = s2_byp_flg;
        end else if (s2_sum == '0) begin
            res_n = {s2_sub ? 1'b0 : s2_sign, {(W-1){1'b0}}};
        end else if (fe >= {2'b00, EXP_ONES}) begin
            res_n          = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
            flg_n.overflow = 1'b1;
            flg_n.inexact  = 1'b1;
        end else begin
            res_n         = {s2_sign, fe[EXP_W-1:0], rm[MAN_W-1:0]};
            flg_n.inexact = |nm[2:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else if (s3_load) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                result <= res_n;
                flags  <= flg_n;
            end
        end
    end

endmodule

// File: tb/tb_fp_add_pipe.sv
// Directed and randomized checks of fp_add_pipe against an exact-integer FP32 reference model.
module tb_fp_add_pipe;
    logic        clk, rst_n;
    logic        in_valid, in_ready, op, out_valid, out_ready;
    logic [31:0] a, b, result;
    logic [2:0]  flags;
    logic        h_in_valid, h_in_ready, h_op, h_out_valid, h_out_ready;
    logic [15:0] h_a, h_b, h_result;
    logic [2:0]  h_flags;

    int          checks, errors, accepts;
    logic [34:0] exp_q[$];

    fp_add_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags)
    );

    fp_add_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .rst_n(rst_n), .in_valid(h_in_valid), .in_ready(h_in_ready), .op(h_op),
        .a(h_a), .b(h_b), .out_valid(h_out_valid), .out_ready(h_out_ready),
        .result(h_result), .flags(h_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Exact model: both operands become integers in units of 2^-149, then the sum is rounded RNE.
    function automatic logic [34:0] ref_add(input logic [31:0] x, input logic [31:0] y, input logic sub);
        logic         sx, sy, nx, ny, snx, sny, ix, iy, rs, up;
        logic [7:0]   ex, ey;
        logic [22:0]  fx, fy;
        logic [299:0] mx, my, m, q, rem, half;
        int           p, sh, e;
        sx = x[31];       ex = x[30:23]; fx = x[22:0];
        sy = y[31] ^ sub; ey = y[30:23]; fy = y[22:0];
        nx = (ex == 8'hFF) && (fx != 0); snx = nx && !fx[22];
        ny = (ey == 8'hFF) && (fy != 0); sny = ny && !fy[22];
        ix = (ex == 8'hFF) && (fx == 0);
        iy = (ey == 8'hFF) && (fy == 0);
        if (nx || ny || (ix && iy && sx != sy))
            return {(ix && iy && sx != sy) || snx || sny, 2'b00, 32'h7FC00000};
        if (ix) return {3'b000, sx, 31'h7F800000};
        if (iy) return {3'b000, sy, 31'h7F800000};
        mx = 300'({ex != 0, fx}) << ((ex == 0) ? 0 : int'(ex) - 1);
        my = 300'({ey != 0, fy}) << ((ey == 0) ? 0 : int'(ey) - 1);
        if (sx == sy) begin m = mx + my; rs = sx; end
        else if (mx >= my) begin m = mx - my; rs = sx; end
        else begin m = my - mx; rs = sy; end
        if (m == 0) return {3'b000, sx && sy, 31'h0};
        p = 0;
        for (int i = 0; i < 300; i++) if (m[i]) p = i;
        if (p <= 23) return {3'b000, rs, m[30:0]};
        sh   = p - 23;
        q    = m >> sh;
        rem  = m & ((300'(1) << sh) - 300'(1));
        half = 300'(1) << (sh - 1);
        up   = (rem > half) || (rem == half && q[0]);
        q    = q + 300'(up);
        if (q[24]) begin q = q >> 1; sh++; end
        e = sh + 1;
        if (e >= 255) return {3'b011, rs, 31'h7F800000};
        return {2'b00, rem != 0, rs, 8'(e), q[22:0]};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [7:0]  e;
        logic [22:0] f;
        f = 23'($urandom);
        case ($urandom_range(0, 9))
            0: e = 8'h00;
            1: begin e = 8'h00; f = '0; end
            2: begin e = 8'hFF; if ($urandom_range(0, 1) == 0) f = '0; end
            3: e = 8'hFE;
            4: e = 8'h01;
            default: e = 8'($urandom_range(100, 154));
        endcase
        return {1'($urandom_range(0, 1)), e, f};
    endfunction

    task automatic rand_pair(output logic [31:0] x, output logic [31:0] y);
        x = rand_fp();
        case ($urandom_range(0, 3))
            0: y = {~x[31], x[30:0] ^ 31'($urandom_range(0, 255))};
            1: y = {1'($urandom_range(0, 1)), x[30:23] - 8'd1, 23'($urandom)};
            default: y = rand_fp();
        endcase
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock of scoreboarded traffic: drive at negedge, observe settled handshakes 1ns later.
    task automatic cycle(input logic v, input logic [31:0] xa, input logic [31:0] xb,
                         input logic xop, input logic ordy);
        logic [34:0] e;
        @(negedge clk);
        in_valid = v; a = xa; b = xb; op = xop; out_ready = ordy;
        #1;
        if (out_valid && !out_ready && exp_q.size() != 0)
            check("stall_head", 64'({flags, result}), 64'(exp_q[0]));
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL spurious_output observed=%0h expected=none", result);
                end
            end else begin
                e = exp_q.pop_front();
                check("result", 64'({flags, result}), 64'(e));
            end
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(ref_add(xa, xb, xop));
            accepts++;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL drain observed=%0d_pending expected=0", exp_q.size());
        end
    endtask

    task automatic directed(input string tag, input logic [31:0] xa, input logic [31:0] xb,
                            input logic xop, input logic [31:0] er, input logic [2:0] ef);
        @(negedge clk);
        in_valid = 1'b1; a = xa; b = xb; op = xop; out_ready = 1'b1;
        #1 check({tag, "_accept"}, 64'(in_ready), 64'(1));
        @(negedge clk);
        in_valid = 1'b0;
        #1 check({tag, "_lat1"}, 64'(out_valid), 64'(0));
        @(negedge clk);
        #1 check({tag, "_lat2"}, 64'(out_valid), 64'(0));
        @(negedge clk);
        #1 check({tag, "_lat3"}, 64'(out_valid), 64'(1));
        check(tag, 64'({flags, result}), 64'({ef, er}));
    endtask

    initial begin
        logic [31:0] x, y;
        checks = 0; errors = 0; accepts = 0;
        rst_n = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; op = 1'b0; out_ready = 1'b0;
        h_in_valid = 1'b0; h_a = '0; h_b = '0; h_op = 1'b0; h_out_ready = 1'b1;

        // Reset state and release
        repeat (2) @(negedge clk);
        #1;
        check("reset_in_ready", 64'(in_ready), 64'(0));
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_result", 64'(result), 64'(0));
        check("reset_flags", 64'(flags), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("release_in_ready", 64'(in_ready), 64'(1));

        // Directed vectors
        directed("one_plus_two", 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000);
        directed("inf_minus_inf", 32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b100);
        directed("overflow", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011);
        directed("sub_plus_sub", 32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 3'b000);
        directed("min_norm_minus_sub", 32'h00800000, 32'h007FFFFF, 1'b1, 32'h00000001, 3'b000);
        directed("tie_to_even", 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001);
        directed("tie_round_up", 32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b001);
        directed("x_minus_x", 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000);
        directed("negzero_sum", 32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000);
        directed("snan_plus_one", 32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100);
        directed("inf_plus_finite", 32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 3'b000);

        // Half-precision instance
        @(negedge clk);
        h_in_valid = 1'b1; h_a = 16'h3C00; h_b = 16'h4000; h_op = 1'b0;
        #1 check("half_accept", 64'(h_in_ready), 64'(1));
        @(negedge clk);
        h_in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1 check("half_valid", 64'(h_out_valid), 64'(1));
        check("half_one_plus_two", 64'({h_flags, h_result}), 64'({3'b000, 16'h4200}));

        // Backpressure: out_ready low for 5 cycles
        accepts = 0;
        for (int i = 0; i < 5; i++) begin
            rand_pair(x, y);
            cycle(1'b1, x, y, 1'($urandom_range(0, 1)), 1'b0);
        end
        check("stall_accepts", 64'(accepts), 64'(3));
        check("stall_in_ready", 64'(in_ready), 64'(0));
        drain();

        // Random traffic with random backpressure
        for (int i = 0; i < 600; i++) begin
            rand_pair(x, y);
            cycle($urandom_range(0, 3) != 0, x, y, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
        end
        drain();

        // Asynchronous reset mid-stream
        for (int i = 0; i < 4; i++) begin
            rand_pair(x, y);
            cycle(1'b1, x, y, 1'b0, 1'b1);
        end
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_in_ready", 64'(in_ready), 64'(0));
        check("midrst_result", 64'({flags, result}), 64'(0));
        exp_q.delete();
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_release_ready", 64'(in_ready), 64'(1));
        check("midrst_release_valid", 64'(out_valid), 64'(0));
        for (int i = 0; i < 60; i++) begin
            rand_pair(x, y);
            cycle(1'b1, x, y, 1'($urandom_range(0, 1)), $urandom_range(0, 1) != 0);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
